// File: rtl/morse_msg_sequencer.sv
// Morse letter queue and scheduler: buffers up to four letter codes and shifts each
// 12-bit pattern out MSB first, one bit per divider tick, followed by a silence gap.
module morse_msg_sequencer #(
    parameter int unsigned DIV = 250,
    parameter int unsigned GAP = 3
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic [2:0] LetterIn,
    input  logic       LetterValid,
    output logic       LetterReady,
    input  logic       Start,
    input  logic       Abort,
    output logic       DotDashOut,
    output logic       Busy,
    output logic       Done,
    output logic [2:0] Level
);
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PAT_W = 12;
    localparam int unsigned DIV_W = $clog2(DIV);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       fifo_mem [DEPTH];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic             dot_q, dot_d;
    logic             done_q, done_d;
    logic             push, pop, tick;
    logic [PAT_W-1:0] head_pat;

    // Letter code to Morse pattern, MSB sent first
    function automatic logic [PAT_W-1:0] morse_pattern(input logic [2:0] code);
        logic [PAT_W-1:0] pat;
        case (code)
            3'd0:    pat = 12'b101110000000;
            3'd1:    pat = 12'b111010101000;
            3'd2:    pat = 12'b111010111010;
            3'd3:    pat = 12'b111010100000;
            3'd4:    pat = 12'b100000000000;
            3'd5:    pat = 12'b101011101000;
            3'd6:    pat = 12'b111011101000;
            default: pat = 12'b101010100000;
        endcase
        return pat;
    endfunction

    assign head_pat    = morse_pattern(fifo_mem[rd_ptr_q]);
    assign LetterReady = (count_q < 3'(DEPTH));
    assign Level       = count_q;
    assign Busy        = (state_q != S_IDLE);
    assign DotDashOut  = dot_q;
    assign Done        = done_q;

    // Sequencer next-state and datapath updates; Abort overrides everything
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        dot_d   = dot_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        tick    = (div_q == '0);

        case (state_q)
            S_IDLE: begin
                dot_d = 1'b0;
                if (Start && (count_q != 3'd0)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pop     = 1'b1;
                shreg_d = head_pat;
                bit_d   = 4'd0;
                dot_d   = head_pat[PAT_W-1];
                div_d   = DIV_RELOAD;
                state_d = S_SEND;
            end
            S_SEND: begin
                div_d = tick ? DIV_RELOAD : (div_q - 1'b1);
                if (tick) begin
                    if (bit_q == 4'(PAT_W - 1)) begin
                        state_d = S_GAP;
                        dot_d   = 1'b0;
                        gap_d   = GAP_RELOAD;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        // rotate so the next bit to send sits in the MSB
                        shreg_d = {shreg_q[PAT_W-2:0], shreg_q[PAT_W-1]};
                        dot_d   = shreg_q[PAT_W-2];
                    end
                end
            end
            S_GAP: begin
                dot_d = 1'b0;
                div_d = tick ? DIV_RELOAD : (div_q - 1'b1);
                if (tick) begin
                    if (gap_q == '0) begin
                        if (count_q != 3'd0) begin
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (Abort) begin
            state_d = S_IDLE;
            dot_d   = 1'b0;
            done_d  = 1'b0;
            pop     = 1'b0;
        end
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        push     = LetterValid && LetterReady && !Abort;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Abort) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            div_q    <= '0;
            bit_q    <= 4'd0;
            gap_q    <= '0;
            shreg_q  <= '0;
            dot_q    <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_mem[i] <= 3'd0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            shreg_q  <= shreg_d;
            dot_q    <= dot_d;
            done_q   <= done_d;
            if (push) begin
                fifo_mem[wr_ptr_q] <= LetterIn;
            end
        end
    end

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Bench for morse_msg_sequencer: vector table, directed multi-cycle sequences and
// random traffic checked every cycle against a letter-timeline reference model.
module tb_morse_msg_sequencer;
    localparam int DIV  = 4;
    localparam int GAP  = 3;
    localparam int SPAN = (12 + GAP) * DIV;

    logic       ClockIn;
    logic       Resetn;
    logic [2:0] LetterIn;
    logic       LetterValid;
    logic       LetterReady;
    logic       Start;
    logic       Abort;
    logic       DotDashOut;
    logic       Busy;
    logic       Done;
    logic [2:0] Level;

    morse_msg_sequencer #(.DIV(DIV), .GAP(GAP)) dut (
        .ClockIn(ClockIn), .Resetn(Resetn), .LetterIn(LetterIn),
        .LetterValid(LetterValid), .LetterReady(LetterReady),
        .Start(Start), .Abort(Abort), .DotDashOut(DotDashOut),
        .Busy(Busy), .Done(Done), .Level(Level)
    );

    always #5 ClockIn = ~ClockIn;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queued letters plus the edge at which the current letter loaded
    logic [2:0] mq[$];
    bit         m_run;
    bit         m_done;
    int         m_load;
    logic [2:0] m_cur;
    int         n_edge;

    bit cap_dout [400];
    bit cap_done [400];
    bit cap_busy [400];

    typedef struct {
        bit         v;
        logic [2:0] ltr;
        bit         st;
        bit         ab;
        int         lvl;
        bit         rdy;
        bit         busy;
    } vec_t;
    vec_t tbl [11];

    function automatic logic [11:0] ref_pat(input logic [2:0] code);
        case (code)
            3'd0:    return 12'b101110000000;
            3'd1:    return 12'b111010101000;
            3'd2:    return 12'b111010111010;
            3'd3:    return 12'b111010100000;
            3'd4:    return 12'b100000000000;
            3'd5:    return 12'b101011101000;
            3'd6:    return 12'b111011101000;
            default: return 12'b101010100000;
        endcase
    endfunction

    function automatic bit model_dout();
        int off;
        logic [11:0] p;
        if (!m_run) return 1'b0;
        off = n_edge - m_load;
        if (off < 1 || off > 12 * DIV) return 1'b0;
        p = ref_pat(m_cur);
        return p[11 - (off - 1) / DIV];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (edge %0d)", name, act, exp, n_edge);
        end
    endtask

    task automatic model_edge(input bit v, input logic [2:0] ltr, input bit st, input bit ab);
        int pre;
        bit do_pop;
        bit do_push;
        pre = mq.size();
        m_done = 1'b0;
        if (ab) begin
            mq.delete();
            m_run = 1'b0;
            return;
        end
        do_push = v && (pre < 4);
        do_pop  = m_run && (n_edge == m_load + 1);
        if (m_run && (n_edge == m_load + SPAN + 1)) begin
            if (pre > 0) m_load = n_edge;
            else begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end
        end else if (!m_run && st && pre > 0) begin
            m_run  = 1'b1;
            m_load = n_edge;
        end
        if (do_pop) m_cur = mq.pop_front();
        if (do_push) mq.push_back(ltr);
    endtask

    task automatic compare_all();
        check("dout",  DotDashOut,  model_dout());
        check("busy",  Busy,        m_run);
        check("done",  Done,        m_done);
        check("level", Level,       mq.size());
        check("ready", LetterReady, mq.size() < 4);
    endtask

    task automatic step(input bit v, input logic [2:0] ltr, input bit st, input bit ab);
        LetterValid = v;
        LetterIn    = ltr;
        Start       = st;
        Abort       = ab;
        @(posedge ClockIn);
        n_edge++;
        model_edge(v, ltr, st, ab);
        #1;
        compare_all();
    endtask

    task automatic run_capture(input int n);
        for (int i = 1; i <= n; i++) begin
            step(1'b0, 3'd0, 1'b0, 1'b0);
            cap_dout[i] = DotDashOut;
            cap_done[i] = Done;
            cap_busy[i] = Busy;
        end
    endtask

    task automatic check_pattern(input string name, input logic [11:0] pat, input int first);
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < DIV; j++) begin
                check(name, cap_dout[first + k * DIV + j], pat[11 - k]);
            end
        end
    endtask

    function automatic int first_done(input int n);
        for (int i = 1; i <= n; i++) if (cap_done[i]) return i;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (cap_done[i]) c++;
        return c;
    endfunction

    function automatic int count_busy(input int n);
        int c = 0;
        for (int i = 1; i <= n; i++) if (cap_busy[i]) c++;
        return c;
    endfunction

    task automatic check_reset_outputs(input string name);
        check({name, "_dout"},  DotDashOut,  0);
        check({name, "_busy"},  Busy,        0);
        check({name, "_done"},  Done,        0);
        check({name, "_level"}, Level,       0);
        check({name, "_ready"}, LetterReady, 1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
    task automatic apply_reset();
        #2;
        Resetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        mq.delete();
        m_run  = 1'b0;
        m_done = 1'b0;
        @(posedge ClockIn);
        #1;
        check_reset_outputs("rst_hold");
        Resetn = 1'b1;
    endtask

    initial begin
        int idx;
        ClockIn     = 1'b0;
        Resetn      = 1'b0;
        LetterIn    = 3'd0;
        LetterValid = 1'b0;
        Start       = 1'b0;
        Abort       = 1'b0;
        m_run       = 1'b0;
        m_done      = 1'b0;
        m_load      = 0;
        m_cur       = 3'd0;
        n_edge      = 0;

        tbl[0]  = '{0, 3'd0, 1, 0, 0, 1, 0};
        tbl[1]  = '{1, 3'd0, 0, 0, 1, 1, 0};
        tbl[2]  = '{1, 3'd1, 0, 0, 2, 1, 0};
        tbl[3]  = '{1, 3'd2, 0, 0, 3, 1, 0};
        tbl[4]  = '{1, 3'd3, 0, 0, 4, 0, 0};
        tbl[5]  = '{1, 3'd4, 0, 0, 4, 0, 0};
        tbl[6]  = '{0, 3'd0, 0, 1, 0, 1, 0};
        tbl[7]  = '{1, 3'd5, 0, 1, 0, 1, 0};
        tbl[8]  = '{1, 3'd4, 0, 0, 1, 1, 0};
        tbl[9]  = '{0, 3'd0, 0, 1, 0, 1, 0};
        tbl[10] = '{0, 3'd0, 1, 0, 0, 1, 0};

        repeat (3) @(posedge ClockIn);
        #1;
        check_reset_outputs("reset");
        Resetn = 1'b1;

        // FIFO fill, full, flush and empty-start vectors
        for (int r = 0; r < 11; r++) begin
            step(tbl[r].v, tbl[r].ltr, tbl[r].st, tbl[r].ab);
            check("tbl_level", Level,       tbl[r].lvl);
            check("tbl_ready", LetterReady, tbl[r].rdy);
            check("tbl_busy",  Busy,        tbl[r].busy);
            check("tbl_dout",  DotDashOut,  0);
        end

        // Single letter A: bit timing, gap and Done latency
        step(1, 3'd0, 0, 0);
        step(0, 3'd0, 1, 0);
        run_capture(62);
        check_pattern("t1_bits_A", 12'b101110000000, 1);
        for (int i = 49; i <= 62; i++) check("t1_gap", cap_dout[i], 0);
        check("t1_done_at",   first_done(62), 61);
        check("t1_done_cnt",  count_done(62), 1);
        check("t1_busy_cyc",  count_busy(62), 60);

        // E then H back to back, single Done after H
        step(1, 3'd4, 0, 0);
        step(1, 3'd7, 0, 0);
        step(0, 3'd0, 1, 0);
        run_capture(125);
        check_pattern("t2_bits_E", 12'b100000000000, 1);
        check_pattern("t2_bits_H", 12'b101010100000, 62);
        check("t2_done_at",  first_done(125), 122);
        check("t2_done_cnt", count_done(125), 1);

        // Five pushes, fifth refused; push mid-run joins the same run
        for (int i = 0; i < 5; i++) step(1, 3'(i), 0, 0);
        check("t3_level_full", Level, 4);
        check("t3_ready_full", LetterReady, 0);
        step(0, 3'd0, 1, 0);
        step(0, 3'd0, 0, 0);
        check("t3_level_pop", Level, 3);
        check("t3_ready_pop", LetterReady, 1);
        step(1, 3'd5, 0, 0);
        check("t3_level_push", Level, 4);
        run_capture(320);
        check("t3_done_at",  first_done(320), 303);
        check("t3_done_cnt", count_done(320), 1);

        // Start with an empty queue does nothing
        step(0, 3'd0, 1, 0);
        run_capture(20);
        check("t4_busy", count_busy(20), 0);
        check("t4_done", count_done(20), 0);

        // Abort during C bit 5
        step(1, 3'd2, 0, 0);
        step(1, 3'd3, 0, 0);
        step(0, 3'd0, 1, 0);
        run_capture(21);
        check("t5_pre_busy", Busy, 1);
        step(0, 3'd0, 0, 1);
        check("t5_busy",  Busy, 0);
        check("t5_level", Level, 0);
        check("t5_dout",  DotDashOut, 0);
        check("t5_done",  Done, 0);
        run_capture(80);
        check("t5_no_done", count_done(80), 0);
        step(0, 3'd0, 1, 0);
        run_capture(10);
        check("t5_no_busy", count_busy(10), 0);

        // Reset mid-gap with two letters queued, then G transmits cleanly
        step(1, 3'd0, 0, 0);
        step(1, 3'd1, 0, 0);
        step(1, 3'd2, 0, 0);
        step(0, 3'd0, 1, 0);
        run_capture(55);
        check("t6_level_pre", Level, 2);
        apply_reset();
        step(1, 3'd6, 0, 0);
        step(0, 3'd0, 1, 0);
        run_capture(62);
        check_pattern("t6_bits_G", 12'b111011101000, 1);
        check("t6_done_at", first_done(62), 61);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            idx = (i / 500) % 2;
            step(($urandom_range(0, idx ? 2 : 9) == 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 399) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
